enigma_seq_ctrl: RTL and testbench
==================================

// Module: enigma_seq_ctrl
// PURPOSE
//  Sequencer between the ps2 key decoder and the shared rotor/reflector wiring table.
//  Accepts one plaintext letter, steps the rotors (with the double-step anomaly), then
//  walks the letter through R,M,L,reflector,L^-1,M^-1,R^-1 with 7 serial table lookups.
//  Returns the cipher letter and current rotor positions for the HEX display path.
// PARAMETERS
//  NOTCH_R    21  right-rotor turnover position (V, rotor III)
//  NOTCH_M     4  middle-rotor turnover position (E, rotor II)
//  RST_POS   15'd0  reset positions {L,M,R}, 5 bits each, each 0..25
// PORTS
//  clk          in   1   system clock
//  rst_l        in   1   asynchronous active-low reset
//  key_valid    in   1   plaintext letter offered
//  key_letter   in   5   letter 0..25 (A..Z)
//  key_ready    out  1   controller can accept a letter (high only in IDLE)
//  lut_req      out  1   table lookup issued this cycle
//  lut_sel      out  2   0=R,1=M,2=L,3=reflector
//  lut_inv      out  1   use inverse wiring (backward pass)
//  lut_idx      out  5   table index 0..25
//  lut_data     in   5   table result, valid the cycle after lut_req
//  out_valid    out  1   one-cycle pulse: out_letter valid
//  out_letter   out  5   cipher letter 0..25
//  pos          out  15  {L,M,R} rotor positions
//  busy         out  1   ~key_ready
// BEHAVIOUR
//  Reset: state IDLE; pos=RST_POS; key_ready=1 and busy=0 (both combinational from IDLE).
//   lut_req=0, lut_sel=0, lut_inv=0, lut_idx=0, out_valid=0, out_letter=0.
//  FSM: IDLE -> STEP -> LK0..LK6 -> DONE -> IDLE. Call the accept edge T.
//  IDLE: accept when key_valid&key_ready. Latch key_letter into cur.
//   If key_letter>25: letter dropped, no step, stay IDLE, no out_valid.
//  STEP (cycle T+1), positions captured before update:
//   R <= R+1 mod 26 always.
//   M steps if R==NOTCH_R, or if M==NOTCH_M (double step).
//   L steps if M==NOTCH_M.
//   Wrap 25->0 on every rotor.
//  LKk (cycles T+2..T+8): lut_req=1 with sel/inv per order R,M,L,3,L,M,R.
//   inv=1 for k>=4.
//   lut_idx=(x+p) mod 26, where p = stepped position of the selected rotor (0 for reflector).
//   x = cur for k=0; otherwise the previous stage's result.
//   Stage result=(lut_data-p) mod 26, computed combinationally the cycle after issue.
//   Arithmetic in 6 bits, one conditional +/-26 correction; no division.
//  DONE (T+9): out_letter<=LK6 result; out_valid high exactly during cycle T+10.
//   FSM back in IDLE (key_ready=1) in the same cycle T+10. Latency 10 clocks.
//  key_valid while busy: ignored, not queued; the source must hold it.
//  lut_req low outside LKk; lut_sel/lut_idx hold their last value.
//  Async reset mid-operation: all state restored to reset values; no out_valid.
//   The in-flight letter is lost; positions return to RST_POS.
// CONFIGURATION
//  ENIGMA_POS_LOAD_EN defined: adds inputs pos_load(1) and pos_load_val(15).
//   In IDLE, pos_load=1 sets pos=pos_load_val; fields >25 load as 0.
//   pos_load has priority over key_valid in the same cycle; key_ready=0 that cycle.
//   pos_load ignored when not in IDLE.
//  Undefined: no such ports; positions change only by stepping and reset.
// TESTING (bench models the rotor I/II/III wiring tables and the UKW-B reflector)
//  Reset, pos=AAA, keys A,A,A,A,A -> out B,D,Z,G,O; final pos=AAF.
//  Each key: out_valid exactly 10 clocks after the accept edge; lut_req high 7 cycles.
//  Double step from ADU (pos_load or RST_POS): 3 keys -> pos ADV, AEW, BFX.
//  Wrap: pos ZZZ with NOTCH_R=25 and NOTCH_M=25 -> 1 key -> AAA.
//  key_letter=26 in IDLE -> pos unchanged, no out_valid, key_ready stays 1.
//  key_valid held high during busy -> only 1 letter accepted per 10-cycle pass.
//  rst_l low at T+5 -> out_valid never pulses; pos=RST_POS; key_ready=1 after release.

Source files
------------

// File: rtl/enigma_seq_ctrl.sv
// enigma_seq_ctrl: steps the rotors for each accepted letter, then walks it through seven serial
// lookups on the shared wiring table. Optional ENIGMA_POS_LOAD_EN adds pos_load/pos_load_val.
module enigma_seq_ctrl #(
  parameter logic [4:0]  NOTCH_R = 5'd21,
  parameter logic [4:0]  NOTCH_M = 5'd4,
  parameter logic [14:0] RST_POS = 15'd0
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        key_valid,
  input  logic [4:0]  key_letter,
`ifdef ENIGMA_POS_LOAD_EN
  input  logic        pos_load,
  input  logic [14:0] pos_load_val,
`endif
  output logic        key_ready,
  output logic        lut_req,
  output logic [1:0]  lut_sel,
  output logic        lut_inv,
  output logic [4:0]  lut_idx,
  input  logic [4:0]  lut_data,
  output logic        out_valid,
  output logic [4:0]  out_letter,
  output logic [14:0] pos,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_STEP = 4'd1,
    S_LK0 = 4'd2, S_LK1 = 4'd3, S_LK2 = 4'd4, S_LK3 = 4'd5,
    S_LK4 = 4'd6, S_LK5 = 4'd7, S_LK6 = 4'd8, S_DONE = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] pos_q, pos_d;
  logic [4:0]  cur_q, cur_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_letter_q, out_letter_d;
  logic [1:0]  sel_hold_q, sel_hold_d;
  logic        inv_hold_q, inv_hold_d;
  logic [4:0]  idx_hold_q, idx_hold_d;
  logic        load_s;
  logic [14:0] load_val_s;
  logic [2:0]  stage_s;
  logic        in_lk_s;
  logic [4:0]  prev_res_s;
  logic [4:0]  x_s;

`ifdef ENIGMA_POS_LOAD_EN
  assign load_s     = pos_load;
  assign load_val_s = pos_load_val;
`else
  assign load_s     = 1'b0;
  assign load_val_s = 15'd0;
`endif

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    else            s = s;
    return s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + 6'd26 - {1'b0, b};
    return s[4:0];
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] a);
    return (a == 5'd25) ? 5'd0 : a + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] a);
    return (a > 5'd25) ? 5'd0 : a;
  endfunction

  // Notches are tested on the positions held before this step (double-step anomaly on M).
  function automatic logic [14:0] step_pos(input logic [14:0] p);
    logic m_step, l_step;
    m_step = (p[4:0] == NOTCH_R) || (p[9:5] == NOTCH_M);
    l_step = (p[9:5] == NOTCH_M);
    return {l_step ? inc26(p[14:10]) : p[14:10],
            m_step ? inc26(p[9:5])   : p[9:5],
            inc26(p[4:0])};
  endfunction

  function automatic logic [1:0] sel_for(input logic [2:0] k);
    case (k)
      3'd0:    return 2'd0;
      3'd1:    return 2'd1;
      3'd2:    return 2'd2;
      3'd3:    return 2'd3;
      3'd4:    return 2'd2;
      3'd5:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [4:0] pos_for(input logic [1:0] sel, input logic [14:0] p);
    case (sel)
      2'd0:    return p[4:0];
      2'd1:    return p[9:5];
      2'd2:    return p[14:10];
      default: return 5'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= S_IDLE;
      pos_q        <= RST_POS;
      cur_q        <= 5'd0;
      out_valid_q  <= 1'b0;
      out_letter_q <= 5'd0;
      sel_hold_q   <= 2'd0;
      inv_hold_q   <= 1'b0;
      idx_hold_q   <= 5'd0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      cur_q        <= cur_d;
      out_valid_q  <= out_valid_d;
      out_letter_q <= out_letter_d;
      sel_hold_q   <= sel_hold_d;
      inv_hold_q   <= inv_hold_d;
      idx_hold_q   <= idx_hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    cur_d        = cur_q;
    out_valid_d  = 1'b0;
    out_letter_d = out_letter_q;
    sel_hold_d   = lut_sel;
    inv_hold_d   = lut_inv;
    idx_hold_d   = lut_idx;
    case (state_q)
      S_IDLE: begin
        if (load_s) begin
          pos_d = {clamp26(load_val_s[14:10]), clamp26(load_val_s[9:5]), clamp26(load_val_s[4:0])};
        end else if (key_valid && key_ready) begin
          cur_d   = key_letter;
          state_d = (key_letter <= 5'd25) ? S_STEP : S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        pos_d   = step_pos(pos_q);
        state_d = S_LK0;
      end
      S_LK0, S_LK1, S_LK2, S_LK3, S_LK4, S_LK5: state_d = state_t'(state_q + 4'd1);
      S_LK6:  state_d = S_DONE;
      S_DONE: begin
        out_letter_d = prev_res_s;
        out_valid_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Each stage result feeds the next index in the same cycle, hence the lut_data-to-lut_idx path.
  always_comb begin
    key_ready = (state_q == S_IDLE) && !load_s;
    in_lk_s   = 1'b1;
    case (state_q)
      S_LK0:   stage_s = 3'd0;
      S_LK1:   stage_s = 3'd1;
      S_LK2:   stage_s = 3'd2;
      S_LK3:   stage_s = 3'd3;
      S_LK4:   stage_s = 3'd4;
      S_LK5:   stage_s = 3'd5;
      S_LK6:   stage_s = 3'd6;
      S_DONE:  begin stage_s = 3'd7; in_lk_s = 1'b0; end
      default: begin stage_s = 3'd0; in_lk_s = 1'b0; end
    endcase
    prev_res_s = sub26(lut_data, pos_for(sel_for(stage_s - 3'd1), pos_q));
    x_s        = (state_q == S_LK0) ? cur_q : prev_res_s;
    if (in_lk_s) begin
      lut_req = 1'b1;
      lut_sel = sel_for(stage_s);
      lut_inv = (stage_s >= 3'd4);
      lut_idx = add26(x_s, pos_for(sel_for(stage_s), pos_q));
    end else begin
      lut_req = 1'b0;
      lut_sel = sel_hold_q;
      lut_inv = inv_hold_q;
      lut_idx = idx_hold_q;
    end
  end

  assign busy       = ~key_ready;
  assign out_valid  = out_valid_q;
  assign out_letter = out_letter_q;
  assign pos        = pos_q;

endmodule

// File: tb/tb_enigma_seq_ctrl.sv
// Bench for enigma_seq_ctrl: serves rotor I/II/III + UKW-B wiring and checks against an Enigma model.
module tb_enigma_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        key_valid [3];
  logic [4:0]  key_letter;
  logic        key_ready [3];
  logic        lut_req   [3];
  logic [1:0]  lut_sel   [3];
  logic        lut_inv   [3];
  logic [4:0]  lut_idx   [3];
  logic [4:0]  lut_data  [3];
  logic        out_valid [3];
  logic [4:0]  out_letter[3];
  logic [14:0] pos       [3];
  logic        busy      [3];

  int total = 0;
  int bad   = 0;
  int ml[3], mm[3], mr[3];
  int rl[3] = '{0, 0, 25};
  int rm[3] = '{0, 3, 25};
  int rr[3] = '{0, 20, 25};
  int nr[3] = '{21, 21, 25};
  int nm[3] = '{4, 4, 25};

  always #5 clk = ~clk;

  enigma_seq_ctrl u0 (
    .clk(clk), .rst_l(rst_l), .key_valid(key_valid[0]), .key_letter(key_letter),
`ifdef ENIGMA_POS_LOAD_EN
    .pos_load(1'b0), .pos_load_val(15'd0),
`endif
    .key_ready(key_ready[0]), .lut_req(lut_req[0]), .lut_sel(lut_sel[0]), .lut_inv(lut_inv[0]),
    .lut_idx(lut_idx[0]), .lut_data(lut_data[0]), .out_valid(out_valid[0]),
    .out_letter(out_letter[0]), .pos(pos[0]), .busy(busy[0]));

  enigma_seq_ctrl #(.RST_POS({5'd0, 5'd3, 5'd20})) u1 (
    .clk(clk), .rst_l(rst_l), .key_valid(key_valid[1]), .key_letter(key_letter),
`ifdef ENIGMA_POS_LOAD_EN
    .pos_load(1'b0), .pos_load_val(15'd0),
`endif
    .key_ready(key_ready[1]), .lut_req(lut_req[1]), .lut_sel(lut_sel[1]), .lut_inv(lut_inv[1]),
    .lut_idx(lut_idx[1]), .lut_data(lut_data[1]), .out_valid(out_valid[1]),
    .out_letter(out_letter[1]), .pos(pos[1]), .busy(busy[1]));

  enigma_seq_ctrl #(.NOTCH_R(5'd25), .NOTCH_M(5'd25), .RST_POS({5'd25, 5'd25, 5'd25})) u2 (
    .clk(clk), .rst_l(rst_l), .key_valid(key_valid[2]), .key_letter(key_letter),
`ifdef ENIGMA_POS_LOAD_EN
    .pos_load(1'b0), .pos_load_val(15'd0),
`endif
    .key_ready(key_ready[2]), .lut_req(lut_req[2]), .lut_sel(lut_sel[2]), .lut_inv(lut_inv[2]),
    .lut_idx(lut_idx[2]), .lut_data(lut_data[2]), .out_valid(out_valid[2]),
    .out_letter(out_letter[2]), .pos(pos[2]), .busy(busy[2]));

  // sel 0 = right (III), 1 = middle (II), 2 = left (I), 3 = UKW-B
  function automatic int fwd(int sel, int i);
    string s;
    case (sel)
      0:       s = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
      1:       s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
      2:       s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
      default: s = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    endcase
    return int'(s[i]) - 65;
  endfunction

  function automatic int tab(int sel, int inv, int i);
    if (i > 25) return 0;
    if (inv == 0) return fwd(sel, i);
    for (int j = 0; j < 26; j++) if (fwd(sel, j) == i) return j;
    return 0;
  endfunction

  function automatic int rotor(int sel, int p, int c, int inv);
    return (tab(sel, inv, (c + p) % 26) - p + 26) % 26;
  endfunction

  function automatic int cipher(int l, int m, int r, int c);
    int x;
    x = rotor(0, r, c, 0);
    x = rotor(1, m, x, 0);
    x = rotor(2, l, x, 0);
    x = fwd(3, x);
    x = rotor(2, l, x, 1);
    x = rotor(1, m, x, 1);
    return rotor(0, r, x, 1);
  endfunction

  function automatic logic [14:0] mpos(int u);
    return 15'(ml[u] * 1024 + mm[u] * 32 + mr[u]);
  endfunction

  task automatic model_step(int u);
    bit ms, ls;
    ms = (mr[u] == nr[u]) || (mm[u] == nm[u]);
    ls = (mm[u] == nm[u]);
    mr[u] = (mr[u] + 1) % 26;
    if (ms) mm[u] = (mm[u] + 1) % 26;
    if (ls) ml[u] = (ml[u] + 1) % 26;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin ml[u] = rl[u]; mm[u] = rm[u]; mr[u] = rr[u]; end
  endtask

  always @(posedge clk)
    for (int u = 0; u < 3; u++)
      if (lut_req[u]) lut_data[u] <= 5'(tab(int'(lut_sel[u]), int'(lut_inv[u]), int'(lut_idx[u])));

  // one letter through unit u: checks latency, lookup count, pulse width, cipher and positions
  task automatic run_key(input int u, input int letter, output int got);
    int lat, reqs, pulses, expv;
    total++;
    if (key_ready[u] !== 1'b1) begin bad++; $display("FAIL pre_ready u%0d got=%b want=1", u, key_ready[u]); end
    key_letter = 5'(letter);
    key_valid[u] = 1'b1;
    @(posedge clk); #1;
    key_valid[u] = 1'b0;
    model_step(u);
    expv = cipher(ml[u], mm[u], mr[u], letter);
    lat = -1; reqs = 0; pulses = 0; got = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (lut_req[u]) reqs++;
      if (out_valid[u]) begin pulses++; if (lat < 0) lat = c; got = int'(out_letter[u]); end
    end
    total++; if (lat != 9)      begin bad++; $display("FAIL latency u%0d got=%0d want=9 (edges after accept)", u, lat); end
    total++; if (reqs != 7)     begin bad++; $display("FAIL lut_req_cycles u%0d got=%0d want=7", u, reqs); end
    total++; if (pulses != 1)   begin bad++; $display("FAIL out_pulses u%0d got=%0d want=1", u, pulses); end
    total++; if (got != expv)   begin bad++; $display("FAIL cipher u%0d in=%0d got=%0d want=%0d", u, letter, got, expv); end
    total++; if (pos[u] !== mpos(u)) begin bad++; $display("FAIL pos u%0d got=%h want=%h", u, pos[u], mpos(u)); end
  endtask

  task automatic test_reset();
    total++; if (key_ready[0] !== 1'b1)  begin bad++; $display("FAIL rst_key_ready got=%b want=1", key_ready[0]); end
    total++; if (busy[0] !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want=0", busy[0]); end
    total++; if (lut_req[0] !== 1'b0)    begin bad++; $display("FAIL rst_lut_req got=%b want=0", lut_req[0]); end
    total++; if (lut_sel[0] !== 2'd0)    begin bad++; $display("FAIL rst_lut_sel got=%0d want=0", lut_sel[0]); end
    total++; if (lut_inv[0] !== 1'b0)    begin bad++; $display("FAIL rst_lut_inv got=%b want=0", lut_inv[0]); end
    total++; if (lut_idx[0] !== 5'd0)    begin bad++; $display("FAIL rst_lut_idx got=%0d want=0", lut_idx[0]); end
    total++; if (out_valid[0] !== 1'b0)  begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid[0]); end
    total++; if (out_letter[0] !== 5'd0) begin bad++; $display("FAIL rst_out_letter got=%0d want=0", out_letter[0]); end
    for (int u = 0; u < 3; u++) begin
      total++; if (pos[u] !== mpos(u)) begin bad++; $display("FAIL rst_pos u%0d got=%h want=%h", u, pos[u], mpos(u)); end
    end
  endtask

  task automatic test_known_vector();
    int exp_kv[5] = '{1, 3, 25, 6, 14};
    int got;
    for (int i = 0; i < 5; i++) begin
      run_key(0, 0, got);
      total++; if (got != exp_kv[i]) begin bad++; $display("FAIL aaaaa_%0d got=%0d want=%0d", i, got, exp_kv[i]); end
    end
    total++; if (pos[0] !== {5'd0, 5'd0, 5'd5}) begin bad++; $display("FAIL aaaaa_pos got=%h want=AAF", pos[0]); end
  endtask

  task automatic test_random();
    int got;
    for (int i = 0; i < 16; i++) run_key(0, int'($urandom_range(0, 25)), got);
  endtask

  task automatic test_back_to_back();
    int letter, npulse, e1, e2;
    int at[$];
    int vals[$];
    letter = int'($urandom_range(0, 25));
    key_letter = 5'(letter);
    key_valid[0] = 1'b1;
    @(posedge clk); #1;
    model_step(0); e1 = cipher(ml[0], mm[0], mr[0], letter);
    model_step(0); e2 = cipher(ml[0], mm[0], mr[0], letter);
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) begin at.push_back(c); vals.push_back(int'(out_letter[0])); end
      if (c == 19) key_valid[0] = 1'b0;
    end
    npulse = at.size();
    total++;
    if (npulse != 2) begin bad++; $display("FAIL held_pulse_count got=%0d want=2", npulse); end
    else begin
      total++; if (at[0] != 9 || at[1] != 19) begin bad++; $display("FAIL held_pulse_times got=%0d,%0d want=9,19", at[0], at[1]); end
      total++; if (vals[0] != e1 || vals[1] != e2) begin bad++; $display("FAIL held_cipher got=%0d,%0d want=%0d,%0d", vals[0], vals[1], e1, e2); end
    end
    total++; if (pos[0] !== mpos(0)) begin bad++; $display("FAIL held_pos got=%h want=%h", pos[0], mpos(0)); end
  endtask

  task automatic test_bad_letter();
    int pulses, busy_seen;
    for (int i = 0; i < 3; i++) begin
      key_letter = 5'(26 + int'($urandom_range(0, 5)));
      key_valid[0] = 1'b1;
      @(posedge clk); #1;
      key_valid[0] = 1'b0;
      pulses = 0; busy_seen = 0;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        if (out_valid[0]) pulses++;
        if (key_ready[0] !== 1'b1) busy_seen++;
      end
      total++; if (pulses != 0)    begin bad++; $display("FAIL bad_letter_out got=%0d want=0 pulses", pulses); end
      total++; if (busy_seen != 0) begin bad++; $display("FAIL bad_letter_ready got=%0d want=0 not-ready cycles", busy_seen); end
      total++; if (pos[0] !== mpos(0)) begin bad++; $display("FAIL bad_letter_pos got=%h want=%h", pos[0], mpos(0)); end
    end
  endtask

  task automatic test_double_step();
    logic [14:0] want[3] = '{{5'd0, 5'd3, 5'd21}, {5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}};
    int got;
    for (int i = 0; i < 3; i++) begin
      run_key(1, int'($urandom_range(0, 25)), got);
      total++; if (pos[1] !== want[i]) begin bad++; $display("FAIL double_step_%0d got=%h want=%h", i, pos[1], want[i]); end
    end
  endtask

  task automatic test_wrap();
    int got;
    run_key(2, int'($urandom_range(0, 25)), got);
    total++; if (pos[2] !== 15'd0) begin bad++; $display("FAIL wrap_pos got=%h want=0 (AAA)", pos[2]); end
  endtask

  task automatic test_reset_mid();
    int pulses, nready;
    key_letter = 5'($urandom_range(0, 25));
    key_valid[0] = 1'b1;
    @(posedge clk); #1;
    key_valid[0] = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 4; c++) begin @(posedge clk); #1; if (out_valid[0]) pulses++; end
    rst_l = 1'b0;
    #1;
    model_reset();
    total++; if (pos[0] !== mpos(0)) begin bad++; $display("FAIL midrst_pos got=%h want=%h", pos[0], mpos(0)); end
    total++; if (key_ready[0] !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", key_ready[0]); end
    total++; if (lut_req[0] !== 1'b0) begin bad++; $display("FAIL midrst_lut_req got=%b want=0", lut_req[0]); end
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    nready = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) pulses++;
      if (key_ready[0] !== 1'b1) nready++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_out got=%0d want=0 pulses", pulses); end
    total++; if (nready != 0) begin bad++; $display("FAIL midrst_ready_after got=%0d want=0 not-ready cycles", nready); end
    for (int u = 1; u < 3; u++) begin
      total++; if (pos[u] !== mpos(u)) begin bad++; $display("FAIL midrst_pos u%0d got=%h want=%h", u, pos[u], mpos(u)); end
    end
  endtask

  initial begin
    rst_l = 1'b0;
    key_letter = 5'd0;
    for (int u = 0; u < 3; u++) key_valid[u] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_known_vector();
    test_random();
    test_back_to_back();
    test_bad_letter();
    test_reset_mid();
    test_double_step();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
